booth_seq_mul: RTL and testbench
================================

# booth_seq_mul

Sequential signed multiplier for the datapath's MUL instruction, the multi-cycle counterpart to the combinational divider that serves DIV. It accepts two WIDTH-bit two's-complement operands on a start pulse and iterates a Booth recoding loop. It then returns the 2·WIDTH-bit product split into HI and LO words, which feed the HI/LO registers. A start/busy/done handshake lets the control unit stall the pipeline while a multiply is in flight.

## Interface
- WIDTH, 32, operand width in bits; must be even and ≥ 4.
- clk  in  1  system clock, rising edge.
- clr  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only when the block is accepting.
- multiplicand  in  WIDTH  signed operand M.
- multiplier  in  WIDTH  signed operand Q.
- busy  out  1  high while a multiply is in progress.
- done  out  1  one-cycle pulse when the product is updated.
- product_hi  out  WIDTH  upper half of the signed product.
- product_lo  out  WIDTH  lower half of the signed product.

## Operation
- States:
  - IDLE: waiting for a request.
  - RUN: iterating the Booth loop.
  - DONE: result just written.
- Acceptance: start is accepted in IDLE or DONE. Acceptance latches M and Q, clears the accumulator and iteration counter, and moves to RUN.
- Starts during RUN are ignored. Operand changes during RUN have no effect.
- RUN performs N iterations:
  - N = WIDTH/2 with radix-4; N = WIDTH with radix-2 (see Configuration).
  - Each iteration selects an operand from the recoded multiplier bits, adds it to the accumulator, then arithmetic-shifts the accumulator/Q pair right (1 bit for radix-2, 2 bits for radix-4).
  - Radix-4 selects from {0, ±M, ±2M}; radix-2 selects from {0, ±M}.
- Accumulator width: WIDTH+2 bits, so that ±2M and the sign are representable. Arithmetic wraps modulo 2^(WIDTH+2).
- After the final iteration, state goes to DONE, the full product is written to product_hi/product_lo, and done is high for that cycle.
- DONE with no start → IDLE on the next edge. DONE with start → RUN directly.
- Product outputs hold their last value at all other times, including throughout a following RUN.
- Zero operands need no special case; the loop yields 0.
- Result is exact for all operand pairs, including (−2^(WIDTH−1))².

## Timing
- Reset values: busy=0, done=0, product_hi=0, product_lo=0, state IDLE.
- clr asserted at any time, including mid-RUN, aborts the operation immediately. No partial result is written.
- Start accepted at edge k:
  - busy=1 from after edge k up to and including edge k+N−1.
  - At edge k+N: busy=0, done=1, products valid.
  - At edge k+N+1: done=0.
- Latency is N cycles from accepting edge to done. Sustained throughput is one multiply per N+1 cycles (start held high through DONE).
- busy and done are never high simultaneously.

## Configuration
- BOOTH_RADIX4_EN defined: radix-4 bit-pair recoding, N = WIDTH/2 (16 cycles at WIDTH=32).
- BOOTH_RADIX4_EN undefined: radix-2 Booth, N = WIDTH (32 cycles).
- Interface, handshake and results are identical in both builds; only latency differs.

## Structure
- Package mul_pkg holds:
  - the state enum (IDLE/RUN/DONE);
  - the default WIDTH;
  - the Booth operation encoding (ZERO, PLUS_M, MINUS_M, PLUS_2M, MINUS_2M);
  - the iteration-count localparam derived from BOOTH_RADIX4_EN.
- Sub-module booth_recoder: combinational. It maps the current multiplier bit group (pair or triplet) to the operation encoding. The top level holds the FSM, counter, accumulator and output registers.

## Test plan
- 100 × 5 → product_hi=0x00000000, product_lo=0x000001F4; done exactly N cycles after the accepting edge (16 with BOOTH_RADIX4_EN, 32 without).
- 0xFFFFFFF9 (−7) × 200 → product_hi=0xFFFFFFFF, product_lo=0xFFFFFA88.
- 0x7FFFFFFF × 0x0000FFFF → product_hi=0x00007FFF, product_lo=0x7FFF0001.
- 0x80000000 × 0x80000000 → product_hi=0x40000000, product_lo=0x00000000.
- Start 3×4, then pulse start with 9×9 mid-RUN → second start ignored; single done with product_lo=12. Start held high through DONE with 9×9 → next done after N+1 cycles, product_lo=81.
- Start 37×6, drop clr at iteration 5 → busy, done and products all 0 immediately, no done pulse. After release, 1×1 → product_lo=1.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared types and constants for the sequential Booth multiplier.
// BOOTH_RADIX4_EN selects radix-4 recoding (WIDTH/2 iterations) instead of radix-2 (WIDTH iterations).
package mul_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  typedef enum logic [2:0] {
    ZERO,
    PLUS_M,
    MINUS_M,
    PLUS_2M,
    MINUS_2M
  } booth_op_t;

  function automatic int booth_iters(input int width);
`ifdef BOOTH_RADIX4_EN
    return width / 2;
`else
    return width;
`endif
  endfunction

  localparam int ITER_COUNT = booth_iters(DEFAULT_WIDTH);

endpackage

// File: rtl/booth_recoder.sv
// Combinational Booth recoder: multiplier bit group {q[i+1], q[i], q[i-1]} to add/subtract operation.
// BOOTH_RADIX4_EN uses the full triplet; otherwise only the low pair {q[i], q[i-1]} matters.
module booth_recoder
  import mul_pkg::*;
(
  input  logic [2:0] grp,
  output booth_op_t  op
);

`ifdef BOOTH_RADIX4_EN
  always_comb begin
    op = ZERO;
    case (grp)
      3'b001, 3'b010: op = PLUS_M;
      3'b011:         op = PLUS_2M;
      3'b100:         op = MINUS_2M;
      3'b101, 3'b110: op = MINUS_M;
      default:        op = ZERO;
    endcase
  end
`else
  logic unused_hi_bit;
  assign unused_hi_bit = grp[2];

  always_comb begin
    op = ZERO;
    case (grp[1:0])
      2'b01:   op = PLUS_M;
      2'b10:   op = MINUS_M;
      default: op = ZERO;
    endcase
  end
`endif

endmodule

// File: rtl/booth_seq_mul.sv
// Sequential signed Booth multiplier with start/busy/done handshake and HI/LO product outputs.
// BOOTH_RADIX4_EN selects radix-4 (WIDTH/2 cycles); default build is radix-2 (WIDTH cycles).
module booth_seq_mul
  import mul_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product_hi,
  output logic [WIDTH-1:0] product_lo
);

  localparam int N  = booth_iters(WIDTH);
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int AW = WIDTH + 2;

  state_t          state_reg, state_next;
  logic [CW-1:0]   cnt_reg;
  logic [AW-1:0]   m_reg;
  logic [AW-1:0]   acc_reg;
  logic [WIDTH-1:0] q_reg;
  logic            qm1_reg;

  logic            accept;
  logic            last_iter;
  booth_op_t       op;
  logic [AW-1:0]   addend;
  logic [AW-1:0]   sum;
  logic [AW-1:0]   acc_next;
  logic [WIDTH-1:0] q_next;
  logic            qm1_next;

  assign accept    = start && (state_reg != RUN);
  assign last_iter = (state_reg == RUN) && (cnt_reg == CW'(N - 1));

  booth_recoder u_recoder (
    .grp ({q_reg[1:0], qm1_reg}),
    .op  (op)
  );

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) state_next = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last_iter) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = start ? RUN : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Add the selected multiple of M, then shift the {acc, q, q-1} chain right arithmetically.
  always_comb begin
    addend = '0;
    case (op)
      PLUS_M:   addend = m_reg;
      MINUS_M:  addend = -m_reg;
      PLUS_2M:  addend = m_reg << 1;
      MINUS_2M: addend = -(m_reg << 1);
      default:  addend = '0;
    endcase
    sum = acc_reg + addend;
`ifdef BOOTH_RADIX4_EN
    acc_next = {{2{sum[AW-1]}}, sum[AW-1:2]};
    q_next   = {sum[1:0], q_reg[WIDTH-1:2]};
    qm1_next = q_reg[1];
`else
    acc_next = {sum[AW-1], sum[AW-1:1]};
    q_next   = {sum[0], q_reg[WIDTH-1:1]};
    qm1_next = q_reg[0];
`endif
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      cnt_reg    <= '0;
      m_reg      <= '0;
      acc_reg    <= '0;
      q_reg      <= '0;
      qm1_reg    <= 1'b0;
      product_hi <= '0;
      product_lo <= '0;
    end else if (accept) begin
      cnt_reg <= '0;
      m_reg   <= {{2{multiplicand[WIDTH-1]}}, multiplicand};
      acc_reg <= '0;
      q_reg   <= multiplier;
      qm1_reg <= 1'b0;
    end else if (state_reg == RUN) begin
      cnt_reg <= cnt_reg + 1'b1;
      acc_reg <= acc_next;
      q_reg   <= q_next;
      qm1_reg <= qm1_next;
      // After the last shift the full product sits in the low WIDTH bits of acc and all of q.
      if (last_iter) begin
        product_hi <= acc_next[WIDTH-1:0];
        product_lo <= q_next;
      end
    end
  end

endmodule

// File: tb/tb_booth_seq_mul.sv
// Scoreboard bench for booth_seq_mul: directed vectors push expectations, a monitor checks each done pulse.
// Build with BOOTH_RADIX4_EN defined to exercise the radix-4 latency.
module tb_booth_seq_mul;

  localparam int W = 32;
`ifdef BOOTH_RADIX4_EN
  localparam int N = 16;
`else
  localparam int N = 32;
`endif

  logic         clk = 1'b0;
  logic         clr = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] mcand = '0;
  logic [W-1:0] mplier = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int cyc = 0;
  int errors = 0;
  int checks = 0;

  typedef struct {
    string        name;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    int           cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  booth_seq_mul #(.WIDTH(W)) dut (
    .clk          (clk),
    .clr          (clr),
    .start        (start),
    .multiplicand (mcand),
    .multiplier   (mplier),
    .busy         (busy),
    .done         (done),
    .product_hi   (hi),
    .product_lo   (lo)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (clr && done) begin
      chk("busy_done_exclusive", 64'(busy), 64'd0);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done got=done lo=%0h want=no_done", lo);
      end else begin
        mon_e = sb.pop_front();
        $display("done %s hi=%08h lo=%08h cyc=%0d", mon_e.name, hi, lo, cyc);
        chk({mon_e.name, "_hi"}, 64'(hi), 64'(mon_e.hi));
        chk({mon_e.name, "_lo"}, 64'(lo), 64'(mon_e.lo));
        chk({mon_e.name, "_cyc"}, 64'(cyc), 64'(mon_e.cyc));
      end
    end
  end

  task automatic issue(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] eh, input logic [W-1:0] el);
    @(negedge clk);
    mcand  = a;
    mplier = b;
    start  = 1'b1;
    sb.push_back('{nm, eh, el, cyc + 1 + N});
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 4 * N + 20) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout got=%0d pending want=0", sb.size());
      sb.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int c;
    repeat (3) @(negedge clk);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_hi", 64'(hi), 64'd0);
    chk("reset_lo", 64'(lo), 64'd0);
    clr = 1'b1;
    @(negedge clk);

    issue("100x5", 32'd100, 32'd5, 32'h0000_0000, 32'h0000_01F4);
    drain();
    issue("m7x200", 32'hFFFF_FFF9, 32'd200, 32'hFFFF_FFFF, 32'hFFFF_FA88);
    drain();
    issue("max_x_ffff", 32'h7FFF_FFFF, 32'h0000_FFFF, 32'h0000_7FFF, 32'h7FFF_0001);
    drain();
    issue("min_sq", 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
    drain();

    // Second start mid-run must be ignored.
    issue("3x4", 32'd3, 32'd4, 32'd0, 32'd12);
    repeat (4) @(negedge clk);
    mcand  = 32'd9;
    mplier = 32'd9;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain();

    // Start held high through DONE: back-to-back multiplies every N+1 cycles.
    @(negedge clk);
    mcand  = 32'd9;
    mplier = 32'd9;
    start  = 1'b1;
    c = cyc;
    sb.push_back('{"9x9_a", 32'd0, 32'd81, c + 1 + N});
    sb.push_back('{"9x9_b", 32'd0, 32'd81, c + 2 + 2 * N});
    while (cyc < c + N + 2) @(negedge clk);
    start = 1'b0;
    drain();

    // Abort mid-run: everything clears at once and no done follows.
    @(negedge clk);
    mcand  = 32'd37;
    mplier = 32'd6;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    chk("abort_busy_before", 64'(busy), 64'd1);
    clr = 1'b0;
    #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_hi", 64'(hi), 64'd0);
    chk("abort_lo", 64'(lo), 64'd0);
    repeat (3) @(negedge clk);
    clr = 1'b1;
    repeat (N + 5) @(negedge clk);

    issue("1x1", 32'd1, 32'd1, 32'd0, 32'd1);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
